bin2bcd_conv: RTL and testbench
===============================

# bin2bcd_conv

Iterative binary-to-BCD converter (shift-and-add-3) that turns a binary count into four packed BCD digits for the 7-segment multiplexer. It sits directly upstream of the display mux and drives its `bcdint[15:0]` input from `bcd_out`. A committed result changes only on completion, so the display never samples a partially converted value. Inputs above 9999 saturate to 9999 and raise an overflow flag.

## Interface

- `WIDTH`, default 14, binary input width; legal range 4..14.
- `clk50`  in  1  system clock, 50 MHz; all state changes on its rising edge.
- `sys_init_ctrl_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request; sampled only in IDLE.
- `bin_in`  in  WIDTH  unsigned binary value; sampled on the accepting edge only.
- `busy`  out  1  high while a conversion is in progress (SHIFT state).
- `done`  out  1  one-cycle pulse; `bcd_out` and `ovf` are updated on the same edge.
- `ovf`  out  1  last accepted input exceeded 9999; held until the next commit.
- `bcd_out`  out  16  packed BCD result; [3:0] is ones, [15:12] is thousands.

## Operation

- Reset (asynchronous assert, at any time including mid-conversion):
  - state goes to IDLE.
  - `busy`, `done` and `ovf` go to 0; `bcd_out` goes to 16'h0000.
  - shift counter, binary shift register and BCD scratch register are cleared.
- FSM states: IDLE and SHIFT.
- IDLE -> SHIFT when `start`=1. On that edge:
  - the saturated input is loaded (`bin_in` > 9999 -> 9999, raw otherwise).
  - the pending overflow bit (`bin_in` > 9999) is stored internally; `ovf` does not change yet.
  - scratch is set to 0 and the counter to WIDTH.
- SHIFT, on each edge:
  - each scratch nibble >= 5 gets +3.
  - then {scratch, binreg} shifts left by 1.
  - the counter decrements.
- SHIFT -> IDLE on the edge where the counter is 1. On that edge:
  - `bcd_out` takes the final shifted scratch value.
  - `ovf` takes the pending overflow bit.
  - `done` is set to 1.
- `done` clears on the next edge unconditionally.
- `start` in SHIFT is ignored; there is no queueing.
- `start` held high continuously causes back-to-back conversions: the next one is accepted on the first IDLE edge.
- Width and arithmetic rules:
  - scratch is 16 bits (4 nibbles).
  - nibble correction is a 4-bit add; since correction happens before the shift, a nibble never exceeds 9 after a shift.
  - for WIDTH < 14 saturation never triggers and `ovf` stays 0.

## Timing

- `start` sampled at edge E (IDLE).
- `busy`=1 from E to E+WIDTH.
- `bcd_out`, `ovf` and `done`=1 are all valid after edge E+WIDTH.
- `done` drops at E+WIDTH+1.
- Earliest next accept is E+WIDTH+1. Throughput is one conversion per WIDTH+1 cycles.
- `bcd_out` is stable in every cycle except the commit edge. The downstream mux samples it on its slower display clock and needs no handshake.
- Reset deassertion: the first edge with `sys_init_ctrl_n`=1 may accept `start`.

## Structure

- Package `bcd_pkg` holds:
  - the state enum (IDLE, SHIFT).
  - the constant `BCD4_MAX` = 9999.
  - the constant `BCD_DIGITS` = 4.
- Sub-module `bcd_digit_adj` is combinational, 4-bit in and 4-bit out: in >= 5 ? in+3 : in. It is instantiated 4 times on the scratch nibbles.
- The top module contains the FSM, the counter, the shift registers and the output registers.

## Test plan

- Reset then idle -> `bcd_out`=16'h0000, `busy`=0, `done`=0, `ovf`=0.
- `bin_in`=1234, `start` pulse at edge E -> `busy` high E..E+14, `done` one cycle after E+14, `bcd_out`=16'h1234, `ovf`=0.
- `bin_in`=0, 9, 10, 9999 in sequence -> 16'h0000, 16'h0009, 16'h0010, 16'h9999 respectively, all with `ovf`=0.
- `bin_in`=12000 -> `bcd_out`=16'h9999, `ovf`=1; the next conversion of 42 returns 16'h0042 with `ovf`=0.
- `start` re-pulsed at E+5 with `bin_in`=777 during a conversion of 1234 -> ignored; result 16'h1234, only one `done` pulse.
- `sys_init_ctrl_n` asserted at E+7 mid-conversion -> outputs immediately 0 and state IDLE; a subsequent conversion of 5678 returns 16'h5678 after 14 shift edges.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int unsigned BCD4_MAX   = 9999;
  localparam int unsigned BCD_DIGITS = 4;
endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction used by shift-and-add-3: nibbles of 5 or more get +3
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_conv.sv
// Iterative binary-to-BCD converter. One bit per cycle, WIDTH shift cycles per
// conversion. bcd_out only changes on the commit edge so the display mux can sample freely.
module bin2bcd_conv
  import bcd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk50,
  input  logic             sys_init_ctrl_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [15:0]      bcd_out
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] binreg;
  logic [15:0]      scratch;
  logic [15:0]      scratch_adj;
  logic [15:0]      scratch_shl;
  logic             ovf_pend;
  logic             bin_big;
  logic [WIDTH-1:0] bin_sat;
  logic             load, commit;

  // Saturation compare in 32 bits; for WIDTH < 14 it can never be true.
  assign bin_big = 32'(bin_in) > BCD4_MAX;
  assign bin_sat = bin_big ? WIDTH'(BCD4_MAX) : bin_in;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[4*d +: 4]),
      .dout (scratch_adj[4*d +: 4])
    );
  end

  // Top bit of the corrected scratch falls off; it is always 0 for values <= 9999.
  assign scratch_shl = 16'({scratch_adj, binreg[WIDTH-1]});

  always_ff @(posedge clk50 or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk50 or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      cnt      <= '0;
      binreg   <= '0;
      scratch  <= '0;
      ovf_pend <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd_out  <= 16'h0000;
    end else begin
      done <= commit;
      if (load) begin
        binreg   <= bin_sat;
        ovf_pend <= bin_big;
        scratch  <= '0;
        cnt      <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        binreg  <= {binreg[WIDTH-2:0], 1'b0};
        scratch <= scratch_shl;
        cnt     <= cnt - CW'(1);
      end
      if (commit) begin
        bcd_out <= scratch_shl;
        ovf     <= ovf_pend;
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_conv.sv
// Scoreboard bench for bin2bcd_conv: stimulus pushes decimal-model results,
// a monitor pops and compares on every done pulse.
module tb_bin2bcd_conv;
  localparam int WIDTH = 14;

  logic             clk50 = 1'b0;
  logic             sys_init_ctrl_n;
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy, done, ovf;
  logic [15:0]      bcd_out;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          src;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  bin2bcd_conv #(.WIDTH(WIDTH)) dut (
    .clk50           (clk50),
    .sys_init_ctrl_n (sys_init_ctrl_n),
    .start           (start),
    .bin_in          (bin_in),
    .busy            (busy),
    .done            (done),
    .ovf             (ovf),
    .bcd_out         (bcd_out)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, saturated at 9999.
  function automatic exp_t model(input int v);
    exp_t e;
    int s;
    s = (v > 9999) ? 9999 : v;
    e.bcd = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    e.ovf = (v > 9999);
    e.src = v;
    return e;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk50);
      #1;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(bcd_out), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("bcd_out(%0d)", e.src), 32'(bcd_out), 32'(e.bcd));
          chk($sformatf("ovf(%0d)", e.src), 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  // One conversion with cycle-exact busy/done checks.
  task automatic do_conv(input int v);
    bit bad = 0;
    @(negedge clk50);
    bin_in = WIDTH'(v);
    start  = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk50);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k < WIDTH; k++) begin
      @(posedge clk50);
      #1;
      if (busy !== 1'b1 || done !== 1'b0) bad = 1;
    end
    chk("busy_window", 32'(bad), 32'd0);
    @(posedge clk50);
    #1;
    chk("done_at_E+W", 32'(done), 32'd1);
    chk("busy_at_E+W", 32'(busy), 32'd0);
    @(posedge clk50);
    #1;
    chk("done_drop", 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    int t;
    sys_init_ctrl_n = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #25;
    chk("rst_bcd_out", 32'(bcd_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk50);
    sys_init_ctrl_n = 1'b1;

    do_conv(1234);
    do_conv(0);
    do_conv(9);
    do_conv(10);
    do_conv(9999);
    do_conv(12000);
    do_conv(42);
    do_conv(16383);
    do_conv(10000);

    // start re-pulsed mid-conversion is ignored
    d0 = done_cnt;
    @(negedge clk50);
    bin_in = WIDTH'(1234);
    start  = 1'b1;
    exp_q.push_back(model(1234));
    @(posedge clk50);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk50);
    @(negedge clk50);
    bin_in = WIDTH'(777);
    start  = 1'b1;
    @(posedge clk50);
    @(negedge clk50);
    start = 1'b0;
    repeat (10) @(posedge clk50);
    #2;
    chk("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);
    repeat (20) @(posedge clk50);
    #2;
    chk("no_late_done", 32'(done_cnt - d0), 32'd1);

    // asynchronous reset mid-conversion
    @(negedge clk50);
    bin_in = WIDTH'(4321);
    start  = 1'b1;
    exp_q.push_back(model(4321));
    @(posedge clk50);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk50);
    #2;
    sys_init_ctrl_n = 1'b0;
    #1;
    chk("midrst_bcd_out", 32'(bcd_out), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    @(negedge clk50);
    sys_init_ctrl_n = 1'b1;
    do_conv(5678);

    // randomized values across the full input range
    for (int i = 0; i < 20; i++) do_conv(int'($urandom_range(0, 16383)));

    // start held high: back-to-back conversions every WIDTH+1 cycles
    d0 = done_cnt;
    @(negedge clk50);
    t = int'($urandom_range(0, 16383));
    bin_in = WIDTH'(t);
    start  = 1'b1;
    exp_q.push_back(model(t));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk50);
      #1;
      if (i < 3) begin
        t = int'($urandom_range(0, 12000));
        bin_in = WIDTH'(t);
        exp_q.push_back(model(t));
      end else begin
        start = 1'b0;
      end
      repeat (WIDTH) @(posedge clk50);
    end
    #2;
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd4);

    // drain
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk50);
      t++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
